// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one zero-latency Avalon-MM memory master between two requesters
//   (0 = patch handler, 1 = palette handler). Ownership is round-robin with a
//   bounded hold of MAX_HOLD completed transfers while the other side waits.
//   A transfer is never split: an owner is only dropped when it is idle or
//   when one of its transfers completes.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   r{0,1}_address/read/write/writedata   requester command inputs
//   r{0,1}_waitrequest     stall to requester (1 whenever it is not the owner)
//   r{0,1}_readdata        memory read data, passed straight through
//   mem_address/read/write/writedata      command to the memory master
//   mem_waitrequest, mem_readdata         response from the memory master
//   grant                  one-hot owner, 00 = idle
//   stat_xfer0/1, stat_stall  16-bit saturating statistics
//
// Build option
//   MEM_ARB_STATS_EN  when defined, the stat_* counters are built; otherwise
//                     the stat_* ports are tied to zero.
//
// States
//   S_IDLE | no owner, mem_* driven to zero
//   S_G0   | requester 0 owns the memory port
//   S_G1   | requester 1 owns the memory port

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_waitrequest,
    output logic [DATA_W-1:0] r0_readdata,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_waitrequest,
    output logic [DATA_W-1:0] r1_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [1:0]        grant,
    output logic [15:0]       stat_xfer0,
    output logic [15:0]       stat_xfer1,
    output logic [15:0]       stat_stall
);

    typedef enum logic [1:0] {S_IDLE, S_G0, S_G1} state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_last;
    logic [7:0] r_hold;

    logic       w_act0;
    logic       w_act1;
    logic       w_done;
    logic       w_at_limit;
    logic [8:0] w_hold_inc;

    assign w_act0 = r0_read | r0_write;
    assign w_act1 = r1_read | r1_write;

    assign w_done = ((r_state == S_G0) && w_act0 && !mem_waitrequest) ||
                    ((r_state == S_G1) && w_act1 && !mem_waitrequest);

    // hold keeps counting while the other side is idle, so it may already be
    // past the limit when the other side shows up; >= hands over on the very
    // next completion instead of waiting for a wrap that never comes.
    assign w_hold_inc = {1'b0, r_hold} + 9'd1;
    assign w_at_limit = (w_hold_inc >= 9'(MAX_HOLD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_hold  <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_hold <= 8'd0;
                if (w_next == S_G0)
                    r_last <= 1'b0;
                else if (w_next == S_G1)
                    r_last <= 1'b1;
            end else if (w_done && (r_hold != 8'hFF)) begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_act0 && w_act1)
                    w_next = r_last ? S_G0 : S_G1;
                else if (w_act0)
                    w_next = S_G0;
                else if (w_act1)
                    w_next = S_G1;
            end
            S_G0: begin
                if (!w_act0 || (w_done && w_at_limit && w_act1))
                    w_next = w_act1 ? S_G1 : (w_act0 ? S_G0 : S_IDLE);
            end
            S_G1: begin
                if (!w_act1 || (w_done && w_at_limit && w_act0))
                    w_next = w_act0 ? S_G0 : (w_act1 ? S_G1 : S_IDLE);
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        r0_waitrequest = 1'b1;
        r1_waitrequest = 1'b1;
        case (r_state)
            S_G0: begin
                mem_address    = r0_address;
                mem_read       = r0_read;
                mem_write      = r0_write;
                mem_writedata  = r0_writedata;
                r0_waitrequest = mem_waitrequest;
            end
            S_G1: begin
                mem_address    = r1_address;
                mem_read       = r1_read;
                mem_write      = r1_write;
                mem_writedata  = r1_writedata;
                r1_waitrequest = mem_waitrequest;
            end
            default: ;
        endcase
    end

    assign r0_readdata = mem_readdata;
    assign r1_readdata = mem_readdata;
    assign grant       = {r_state == S_G1, r_state == S_G0};

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_xfer0;
    logic [15:0] r_xfer1;
    logic [15:0] r_stall;
    logic        w_stall_cyc;

    // One increment per cycle, even when both requesters are waiting.
    assign w_stall_cyc = (w_act0 && (r_state != S_G0)) ||
                         (w_act1 && (r_state != S_G1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xfer0 <= 16'd0;
            r_xfer1 <= 16'd0;
            r_stall <= 16'd0;
        end else begin
            if (w_done && (r_state == S_G0) && (r_xfer0 != 16'hFFFF))
                r_xfer0 <= r_xfer0 + 16'd1;
            if (w_done && (r_state == S_G1) && (r_xfer1 != 16'hFFFF))
                r_xfer1 <= r_xfer1 + 16'd1;
            if (w_stall_cyc && (r_stall != 16'hFFFF))
                r_stall <= r_stall + 16'd1;
        end
    end

    assign stat_xfer0 = r_xfer0;
    assign stat_xfer1 = r_xfer1;
    assign stat_stall = r_stall;
`else
    assign stat_xfer0 = 16'd0;
    assign stat_xfer1 = 16'd0;
    assign stat_stall = 16'd0;
`endif

endmodule
